gray_updown_counter: RTL and testbench

//  Parametrised N-bit Gray-code counter; supports up/down counting, enable, synchronous load,
//  and a wrap or saturate mode. State is held directly in a Gray register, so the output is

---
 rtl/gray_updown_counter_pkg.sv | 31 +++
 rtl/gray_updown_counter_gray_to_bin.sv | 19 +
 rtl/gray_updown_counter.sv | 80 ++++++++
 tb/tb_gray_updown_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gray_updown_counter_pkg.sv
// Shared definitions for the Gray up/down counter: next-state selector
// encoding and width-generic Gray/binary conversion helpers. Callers pass
// zero-extended operands and size-cast the result back to their own width.
package gray_pkg;

    localparam int MAX_W = 32;

    // Which source feeds the Gray state register on the coming edge
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STEP  = 2'd2,
        OP_BLOCK = 2'd3
    } op_e;

    // b ^ (b >> 1); zero upper bits stay zero, so any narrower width is exact
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter_gray_to_bin.sv
// Combinational Gray-to-binary converter. Each binary bit is the XOR of all
// Gray bits at or above it, which equals bin[i+1] ^ gray[i] but is written as
// a reduction so no bit of the output vector feeds another.
module gray_to_bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    assign bin[N-1] = gray[N-1];

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_bit
            assign bin[gi] = ^gray[N-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit Gray-code up/down counter with load, enable and wrap/saturate modes.
// The state lives in Gray form so gray_count changes one bit per step; the
// binary view and limit flag are derived combinationally from that state.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_gray,
    output logic [N-1:0] gray_count,
    output logic [N-1:0] bin_count,
    output logic         at_limit,
    output logic         wrap
);

    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] CNT_MIN = '0;
    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_gray;
    logic         r_wrap;
    logic [N-1:0] w_bin;
    logic [N-1:0] w_step_bin;
    logic [N-1:0] w_next_gray;
    logic         w_at_limit;
    op_e          w_op;

    gray_to_bin #(.N(N)) u_gray_to_bin (
        .gray (r_gray),
        .bin  (w_bin)
    );

    // Limit in the current direction; a step from here either wraps or is blocked
    assign w_at_limit  = up ? (w_bin == CNT_MAX) : (w_bin == CNT_MIN);
    // Modulo-2**N neighbour in binary, then back to Gray for the register
    assign w_step_bin  = up ? (w_bin + ONE) : (w_bin - ONE);
    assign w_next_gray = N'(bin2gray(MAX_W'(w_step_bin)));

    // Choose the next-state source: load beats enable, saturation blocks the step
    always_comb begin
        w_op = OP_HOLD;
        if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            if ((SATURATE != 0) && w_at_limit) begin
                w_op = OP_BLOCK;
            end else begin
                w_op = OP_STEP;
            end
        end
    end

    // Gray state register and one-cycle wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            case (w_op)
                OP_LOAD: r_gray <= load_gray;
                OP_STEP: r_gray <= w_next_gray;
                default: r_gray <= r_gray;
            endcase
            // A step taken from the limit is by construction a wrap step
            r_wrap <= (w_op == OP_STEP) && w_at_limit;
        end
    end

    assign gray_count = r_gray;
    assign bin_count  = w_bin;
    assign at_limit   = w_at_limit;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a wrapping and a saturating instance share
// one stimulus stream and are compared each edge against an integer model.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_gray = '0;

    logic [3:0] gray_o [2];
    logic [3:0] bin_o  [2];
    logic       lim_o  [2];
    logic       wrap_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: binary value and wrap flag per instance (0 = wrap mode, 1 = saturate)
    int m_val  [2];
    int m_wrap [2];
    int m_prev_gray [2];
    int m_is_step [2];

    always #5 clk = ~clk;

    gray_updown_counter #(.N(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray_count(gray_o[0]), .bin_count(bin_o[0]), .at_limit(lim_o[0]), .wrap(wrap_o[0])
    );

    gray_updown_counter #(.N(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray_count(gray_o[1]), .bin_count(bin_o[1]), .at_limit(lim_o[1]), .wrap(wrap_o[1])
    );

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    // Inverse by search: the value whose Gray code matches
    function automatic int bin_of(input int g);
        for (int v = 0; v < 16; v++) begin
            if (gray_of(v) == g) return v;
        end
        return -1;
    endfunction

    function automatic int popcount4(input int x);
        int c = 0;
        for (int i = 0; i < 4; i++) c += (x >> i) & 1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s.gray[%0d]", tag, s), 32'(gray_o[s]), 32'(gray_of(m_val[s])));
            chk($sformatf("%s.bin[%0d]", tag, s), 32'(bin_o[s]), 32'(m_val[s]));
            chk($sformatf("%s.wrap[%0d]", tag, s), 32'(wrap_o[s]), 32'(m_wrap[s]));
            chk($sformatf("%s.limit[%0d]", tag, s), 32'(lim_o[s]),
                32'((up && m_val[s] == 15) || (!up && m_val[s] == 0)));
        end
    endtask

    // Apply model rules for the current inputs, take one edge, check both instances
    task automatic tick(input string tag);
        for (int s = 0; s < 2; s++) begin
            m_prev_gray[s] = gray_of(m_val[s]);
            m_is_step[s]   = 0;
            m_wrap[s]      = 0;
            if (load) begin
                m_val[s] = bin_of(int'(load_gray));
                m_is_step[s] = -1;
            end else if (en) begin
                if (s == 1 && ((up && m_val[s] == 15) || (!up && m_val[s] == 0))) begin
                    m_is_step[s] = 0;
                end else begin
                    m_wrap[s] = (up && m_val[s] == 15) || (!up && m_val[s] == 0);
                    m_val[s]  = up ? (m_val[s] + 1) % 16 : (m_val[s] + 15) % 16;
                    m_is_step[s] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        for (int s = 0; s < 2; s++) begin
            if (m_is_step[s] >= 0)
                chk($sformatf("%s.hamming[%0d]", tag, s),
                    32'(popcount4(int'(gray_o[s]) ^ m_prev_gray[s])), 32'(m_is_step[s]));
        end
        $display("[TB] %s en=%0b up=%0b load=%0b lg=%0h -> gray=%0h/%0h wrap=%0b/%0b",
                 tag, en, up, load, load_gray, gray_o[0], gray_o[1], wrap_o[0], wrap_o[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin m_val[s] = 0; m_wrap[s] = 0; end
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    int seq1 [17] = '{4'h0+1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                      4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

    initial begin
        // 1: full up cycle in wrap mode, against the literal Gray sequence
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick("t1_up");
            chk("t1_seq", 32'(gray_o[0]), 32'(seq1[k]));
            chk("t1_wrap", 32'(wrap_o[0]), 32'(k == 15));
        end

        // 2: down from reset wraps to 15 then 14
        do_reset();
        en = 1'b1; up = 1'b0;
        tick("t2_down");
        chk("t2_gray8", 32'(gray_o[0]), 32'h8);
        chk("t2_wrap", 32'(wrap_o[0]), 32'h1);
        tick("t2_down");
        chk("t2_gray9", 32'(gray_o[0]), 32'h9);
        chk("t2_bin14", 32'(bin_o[0]), 32'd14);

        // 3: saturate at 15, stay there, then turn around
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 18; k++) tick("t3_sat");
        chk("t3_hold8", 32'(gray_o[1]), 32'h8);
        chk("t3_limit", 32'(lim_o[1]), 32'h1);
        chk("t3_nowrap", 32'(wrap_o[1]), 32'h0);
        up = 1'b0;
        tick("t3_turn");
        chk("t3_gray9", 32'(gray_o[1]), 32'h9);

        // 4: load wins over enable
        load = 1'b1; load_gray = 4'h5; en = 1'b0;
        tick("t4_load5");
        load_gray = 4'hC; en = 1'b1; up = 1'b0;
        tick("t4_loadC");
        chk("t4_grayC", 32'(gray_o[0]), 32'hC);
        load = 1'b0; up = 1'b1;
        tick("t4_stepD");
        chk("t4_grayD", 32'(gray_o[0]), 32'hD);

        // 5: asynchronous reset between edges
        load = 1'b1; load_gray = 4'h6;
        tick("t5_load6");
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin m_val[s] = 0; m_wrap[s] = 0; end
        #1;
        chk("t5_async0", 32'(gray_o[0]), 32'h0);
        check_all("t5_async");
        @(negedge clk);
        rst = 1'b0;
        tick("t5_first");
        chk("t5_gray1", 32'(gray_o[0]), 32'h1);

        // 6: enable low holds regardless of other inputs
        load = 1'b1; load_gray = 4'hA;
        tick("t6_loadA");
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            up = k[0];
            load_gray = 4'($urandom_range(0, 15));
            tick("t6_hold");
            chk("t6_grayA", 32'(gray_o[0]), 32'hA);
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 3) != 0);
            up        = ($urandom_range(0, 5) != 0) ? up : ~up;
            load      = ($urandom_range(0, 15) == 0);
            load_gray = 4'($urandom_range(0, 15));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
